// File: rtl/tdm_demux16.sv
// 16-slot serial TDM demultiplexer: hunts for fsync, gathers one bit per valid
// beat into an assembly register, and publishes each completed frame on dout.

module tdm_demux16_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic wen,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (wen) q <= d;
  end
endmodule

module tdm_demux16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        din_valid,
  input  logic        fsync,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic [3:0]  slot,
  output logic        busy,
  output logic        sync_err
);
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        start, accept, done, abort;
  logic [15:0] asm_q, asm_wen, asm_d;

  // fsync always wins: in RECV it restarts the frame rather than completing it
  always_comb begin
    start  = din_valid && fsync;
    accept = din_valid && !fsync && (state == RECV);
    done   = accept && (slot == 4'd15);
    abort  = start && (state == RECV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = RECV;
    else if (done) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state == RECV);
  end

  // A start beat clears every stale bit so a partial frame can never leak out
  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_asm
      always_comb begin
        asm_wen[k] = start || (accept && (slot == 4'(k)));
        asm_d[k]   = (start && (k != 0)) ? 1'b0 : din;
      end
      tdm_demux16_bit u_bit (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (asm_wen[k]),
        .d    (asm_d[k]),
        .q    (asm_q[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= 4'd0;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= done;
      sync_err   <= abort;
      if (start)       slot <= 4'd1;
      else if (accept) slot <= slot + 4'd1;  // 15 -> 0 on completion
      if (done)        dout <= {din, asm_q[14:0]};
    end
  end
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: frames, stalls, resyncs, back-to-back and reset.

module tb_tdm_demux16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        din, din_valid, fsync;
  logic [15:0] dout;
  logic        dout_valid, busy, sync_err;
  logic [3:0]  slot;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulse_a, pulse_b;

  tdm_demux16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .dout      (dout),
    .dout_valid(dout_valid),
    .slot      (slot),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later
  task automatic send(input logic v, input logic f, input logic d);
    din_valid = v; fsync = f; din = d;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Full 16-beat frame, LSB first, with optional 3-cycle stalls after slots sa/sb
  task automatic frame(input logic [15:0] data, input int sa, input int sb, input logic serr);
    int vp = 0;
    int sp = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, i == 0, data[i]);
      if (i == 0) chk("serr_first", 16'(sync_err), 16'(serr));
      else        sp += int'(sync_err);
      if (i < 15) vp += int'(dout_valid);
      if (i == 0) chk("slot_after_sync", 16'(slot), 16'd1);
      if (i == sa || i == sb)
        repeat (3) begin
          send(1'b0, 1'b0, 1'b1);
          chk("stall_slot", 16'(slot), 16'(i + 1));
        end
    end
    chk("early_valid", 16'(vp), 16'd0);
    chk("serr_later", 16'(sp), 16'd0);
    chk("dout", dout, data);
    chk("dout_valid", 16'(dout_valid), 16'd1);
    chk("slot_wrap", 16'(slot), 16'd0);
    chk("busy_end", 16'(busy), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; fsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_valid", 16'(dout_valid), 16'd0);
    chk("rst_slot", 16'(slot), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_serr", 16'(sync_err), 16'd0);
    rst_n = 1'b1;

    // Basic frame, then dout must hold with the pulse gone
    frame(16'hA5C3, -1, -1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("pulse_width", 16'(dout_valid), 16'd0);
    chk("dout_hold", dout, 16'hA5C3);

    // Same frame with stalls after slots 4 and 11
    frame(16'hA5C3, 4, 11, 1'b0);
    send(1'b0, 1'b0, 1'b0);

    // 7 beats then a resync carrying 0x1234
    for (int i = 0; i < 7; i++) send(1'b1, i == 0, 1'b1);
    chk("partial_slot", 16'(slot), 16'd7);
    frame(16'h1234, -1, -1, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    chk("serr_cleared", 16'(sync_err), 16'd0);

    // fsync at slot 15 is a resync, not a completion
    for (int i = 0; i < 15; i++) send(1'b1, i == 0, 1'b1);
    chk("slot15", 16'(slot), 16'd15);
    frame(16'h0F0F, -1, -1, 1'b1);

    // Unsynced beats in IDLE are discarded
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 1'b0);
      chk("idle_slot", 16'(slot), 16'd0);
      chk("idle_busy", 16'(busy), 16'd0);
    end
    frame(16'hFFFF, -1, -1, 1'b0);

    // Back-to-back frames, no gap
    frame(16'h0001, -1, -1, 1'b0);
    pulse_a = cyc;
    frame(16'h8000, -1, -1, 1'b0);
    pulse_b = cyc;
    chk("pulse_spacing", 16'(pulse_b - pulse_a), 16'd16);

    // Reset mid-frame at slot 9
    for (int i = 0; i < 9; i++) send(1'b1, i == 0, 1'b1);
    chk("pre_rst_slot", 16'(slot), 16'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 16'h0000);
    chk("mid_rst_slot", 16'(slot), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_valid", 16'(dout_valid), 16'd0);
    chk("mid_rst_serr", 16'(sync_err), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b1, 1'b0, 1'b1);
    chk("post_rst_idle", 16'(busy), 16'd0);
    frame(16'h5A5A, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 The block SHALL have no parameters; the channel count is fixed at 16 and the slot index is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 din  input  1  serial TDM data bit for the current slot.
REQ-005 din_valid  input  1  din (and fsync) are qualified this cycle; when low the cycle SHALL be a stall.
REQ-006 fsync  input  1  frame-sync marker, qualified by din_valid; marks din as slot 0.
REQ-007 dout  output  16  last completed frame; dout[k] = bit received in slot k.
REQ-008 dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-009 slot  output  4  index of the next slot to be accepted (0 in IDLE).
REQ-010 busy  output  1  high while in RECV.
REQ-011 sync_err  output  1  one-cycle pulse on fsync mid-frame (resync event).

Function
REQ-012 The FSM SHALL have two states: IDLE (hunting for fsync) and RECV (collecting slots).
REQ-013 A beat SHALL be a cycle with din_valid=1; a cycle with din_valid=0 SHALL change no state, slot or assembly bit.
REQ-014 In IDLE, a beat with fsync=1 SHALL store din in assembly bit 0, set slot=1 and move to RECV.
REQ-015 In IDLE, a beat with fsync=0 SHALL be discarded, and the block SHALL remain in IDLE with slot=0.
REQ-016 In RECV, a beat with fsync=0 SHALL store din in assembly bit [slot] and increment slot.
REQ-017 In RECV, the beat with slot=15 and fsync=0 SHALL complete the frame.
REQ-018 On frame completion, on the next edge dout SHALL take the full 16-bit assembly (including this beat's bit), dout_valid SHALL pulse for 1 cycle, the state SHALL return to IDLE and slot SHALL wrap to 0.
REQ-019 Latency from the slot-15 beat edge to dout/dout_valid SHALL be 1 clock (both registered).
REQ-020 In RECV, a beat with fsync=1 SHALL abort the partial frame without updating dout or pulsing dout_valid.
REQ-021 On that abort beat, sync_err SHALL pulse for 1 cycle and din SHALL be stored as slot 0 of a new frame, with slot=1 and the state remaining RECV.
REQ-022 A beat with fsync=1 at slot=15 SHALL be treated as an abort and resync, not as a completion.
REQ-023 dout SHALL hold its value between completions; assembly bits not yet written in a frame SHALL NOT reach dout.
REQ-024 Back-to-back frames SHALL be accepted with no gap: the fsync beat may arrive in the cycle directly after the completing beat, in which dout_valid is high, and that beat SHALL start the new frame.
REQ-025 busy SHALL equal (state==RECV); slot SHALL always be in the range 0..15.

Reset
REQ-026 While rst_n=0, the block SHALL set state=IDLE, slot=0, dout=16'h0000, dout_valid=0, sync_err=0, busy=0 and clear the assembly register, independent of clk.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame, and dout SHALL read 16'h0000 afterward.
REQ-028 After rst_n deasserts, the first beat SHALL be handled per IDLE rules at the next rising edge.

Verification
REQ-029 Send 16 consecutive beats with fsync on beat 0, carrying 16'hA5C3 (LSB first) -> dout=16'hA5C3 and dout_valid high for exactly 1 cycle, 1 clock after beat 15; slot returns to 0.
REQ-030 Repeat the REQ-029 frame with din_valid=0 for 3 cycles inserted after slots 4 and 11 -> same dout=16'hA5C3; slot holds during the stalls.
REQ-031 Send 7 beats, then an fsync beat, then 15 further beats with frame 16'h1234 -> sync_err pulses once at the 8th beat; one dout_valid occurs, with dout=16'h1234.
REQ-032 Send beats with fsync=0 while in IDLE, followed by a valid frame 16'hFFFF -> the leading beats are ignored and dout=16'hFFFF.
REQ-033 Send two back-to-back frames, 16'h0001 then 16'h8000, with no idle cycle -> two dout_valid pulses 16 clocks apart, with dout=16'h0001 and then 16'h8000.
REQ-034 Assert rst_n low at slot 9 of a frame, release it, then send frame 16'h5A5A -> all outputs read 0 during reset, and the next dout is 16'h5A5A.
